// File: rtl/block_word_buffer_if.sv
// block_word_buffer_if: word-in / block-out handshake bundle for block_word_buffer
interface block_word_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   blk_valid;
    logic [WIDTH*DEPTH-1:0] blk_data;
    logic [CNT_W-1:0]       blk_cnt;
    logic                   blk_ready;
    modport master (
        output in_valid, in_data, in_last, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_cnt
    );
    modport slave (
        input  in_valid, in_data, in_last, blk_ready,
        output in_ready, blk_valid, blk_data, blk_cnt
    );
endinterface

// File: rtl/block_word_buffer.sv
// block_word_buffer: collects DEPTH words into one zero-filled block with early close
module block_word_buffer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic CLK,
    input logic RST,
    input logic clear,
    block_word_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BW    = WIDTH * DEPTH;
    typedef enum logic {FILL, FULL} state_t;
    state_t           state_q, state_n;
    logic [CNT_W-1:0] idx_q, idx_n, cnt_q, cnt_n, widx;
    logic [BW-1:0]    data_q, data_n;
    logic             acc, rel, close;
    int               off;
    assign bus.in_ready  = !RST && (state_q == FILL || bus.blk_ready);
    assign bus.blk_valid = state_q == FULL;
    assign bus.blk_data  = data_q;
    assign bus.blk_cnt   = cnt_q;
    assign rel   = state_q == FULL && bus.blk_ready;
    assign acc   = bus.in_valid && bus.in_ready;
    // a word arriving on release becomes slot 0 of the next block
    assign widx  = rel ? '0 : idx_q;
    assign close = widx == CNT_W'(DEPTH - 1) || bus.in_last;
    assign off   = MSB_FIRST ? WIDTH * (DEPTH - 1 - int'(widx)) : WIDTH * int'(widx);
    // unwritten slots are already zero, so OR-ing the new word in is enough
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        data_n  = rel ? '0 : data_q;
        if (acc) begin
            data_n  = data_n | (BW'(bus.in_data) << off);
            state_n = close ? FULL : FILL;
            idx_n   = close ? '0 : widx + CNT_W'(1);
            cnt_n   = close ? widx + CNT_W'(1) : '0;
        end else if (rel) begin
            state_n = FILL;
            idx_n   = '0;
            cnt_n   = '0;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
        end
    end
endmodule

// File: tb/tb_block_word_buffer.sv
// tb_block_word_buffer: directed and random stimulus against a block-level reference model
module tb_block_word_buffer;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int BW = W * D;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic clear = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [W-1:0]  cur[$];
    logic [BW-1:0] held_data;
    int            held_cnt;
    bit            held;
    block_word_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();
    block_word_buffer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut (
        .CLK(CLK), .RST(RST), .clear(clear), .bus(bus)
    );
    always #5 CLK = ~CLK;
    // word k of a block lives in slot k, counted from the top of the flat vector
    function automatic logic [BW-1:0] build();
        logic [BW-1:0] f = '0;
        foreach (cur[k]) f = f | (BW'(cur[k]) << (W * (D - 1 - k)));
        return f;
    endfunction
    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step(input bit r, input bit c, input bit v, input logic [W-1:0] d,
                        input bit l, input bit br);
        bit exp_ready;
        @(negedge CLK);
        RST = r; clear = c;
        bus.in_valid = v; bus.in_data = d; bus.in_last = l; bus.blk_ready = br;
        #1;
        exp_ready = !r && (!held || br);
        chk("in_ready", BW'(bus.in_ready), BW'(exp_ready));
        chk("blk_valid", BW'(bus.blk_valid), BW'(held));
        chk("blk_data", bus.blk_data, held ? held_data : build());
        if (held) chk("blk_cnt", BW'(bus.blk_cnt), BW'(held_cnt));
        if (r || c) begin
            cur.delete();
            held = 0;
        end else begin
            if (held && br) held = 0;
            if (v && exp_ready) begin
                cur.push_back(d);
                if (cur.size() == D || l) begin
                    held_data = build();
                    held_cnt  = cur.size();
                    held = 1;
                    cur.delete();
                end
            end
        end
    endtask
    initial begin
        held = 0; held_cnt = 0; held_data = '0;
        bus.in_valid = 1'b1; bus.in_data = '0; bus.in_last = 1'b0; bus.blk_ready = 1'b0;
        @(posedge CLK);
        // reset held with in_valid asserted
        step(1, 0, 1, 32'h1234, 0, 0);
        step(1, 0, 1, 32'h1234, 0, 0);
        chk("rst_cnt", BW'(bus.blk_cnt), '0);
        // full block 0..15, then hold
        for (int i = 0; i < D; i++) step(0, 0, 1, W'(i), 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("full_top", BW'(bus.blk_data[BW-1 -: W]), '0);
        chk("full_bot", BW'(bus.blk_data[W-1:0]), BW'(32'hF));
        chk("full_cnt", BW'(bus.blk_cnt), BW'(D));
        step(0, 0, 0, 0, 0, 1);
        // short block after a full one
        step(0, 0, 1, 32'hA, 0, 0);
        step(0, 0, 1, 32'hB, 0, 0);
        step(0, 0, 1, 32'hC, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("short_cnt", BW'(bus.blk_cnt), BW'(3));
        chk("short_tail", BW'(bus.blk_data[BW-3*W-1:0]), '0);
        // backpressure: pending word stalls, then lands as slot 0 on release
        for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h55, 0, 0);
        step(0, 0, 1, 32'h55, 0, 1);
        for (int i = 1; i < D; i++) step(0, 0, 1, W'(32'h100 + i), 0, 1);
        // streaming 48 words with the consumer always ready
        for (int i = 0; i < 3 * D; i++) step(0, 0, 1, $urandom, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // abort mid-fill, then a clean block, then abort while full
        for (int i = 0; i < 7; i++) step(0, 0, 1, $urandom, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) step(0, 0, 1, $urandom, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("abort_cnt", BW'(bus.blk_cnt), BW'(D));
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 600; i++)
            step(0, $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
